// File: rtl/posit_encode_pipe.sv
// Two-stage pipelined posit encoder: builds the regime/exponent/fraction string,
// then rounds to nearest-even with posit saturation and packs the N-bit result.
module posit_encode_pipe #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) (
    input  logic          Clk_CI,
    input  logic          Rst_RI,
    input  logic          Kill_SI,
    input  logic          In_valid_SI,
    output logic          In_ready_SO,
    input  logic          Sign_DI,
    input  logic [RS+1:0] Regime_DI,
    input  logic [ES-1:0] Exp_DI,
    input  logic [N-1:0]  Mant_DI,
    input  logic          Sticky_DI,
    input  logic          NaR_DI,
    input  logic          Zero_DI,
    output logic          Out_valid_SO,
    input  logic          Out_ready_SI,
    output logic [N-1:0]  Result_DO,
    output logic          Inexact_SO,
    output logic          Invalid_SO
);
    localparam int KW  = RS + 2;
    localparam int SW  = 2 * N;
    localparam int PAD = SW - ES - (N - 1);
    localparam logic signed [KW-1:0] K_MAX = KW'(N - 2);
    localparam logic signed [KW-1:0] K_MIN = KW'(2 - N);

    logic          s1_valid_q, s1_valid_d;
    logic [SW-1:0] str_q, str_d;
    logic          sign_q, sign_d;
    logic          nar_q, nar_d;
    logic          zero_q, zero_d;
    logic          sticky_q, sticky_d;
    logic          sat_q, sat_d;

    logic          s2_valid_q, s2_valid_d;
    logic [N-1:0]  result_q, result_d;
    logic          inexact_q, inexact_d;
    logic          invalid_q, invalid_d;

    logic s2_adv;
    logic in_fire;

    // The hidden bit is implied by the regime encoding and is never stored.
    logic hidden_unused;
    assign hidden_unused = Mant_DI[N-1];

    assign s2_adv      = !s2_valid_q || Out_ready_SI;
    assign In_ready_SO = !Kill_SI && (!s1_valid_q || s2_adv);
    assign in_fire     = In_valid_SI && In_ready_SO;

    logic signed [KW-1:0] k_sat;
    logic                 sat_flag;
    logic [KW-1:0]        k_mag;
    logic [KW-1:0]        reg_len;
    logic [SW-1:0]        regime_bits;
    logic [SW-1:0]        body;
    logic [SW+N-1:0]      wide;
    logic [SW-1:0]        str_next;
    logic                 spill;

    // Bits pushed past the 2N-bit window only matter for stickiness.
    always_comb begin
        k_sat    = $signed(Regime_DI);
        sat_flag = 1'b0;
        if (k_sat > K_MAX) begin
            k_sat    = K_MAX;
            sat_flag = 1'b1;
        end else if (k_sat < K_MIN) begin
            k_sat    = K_MIN;
            sat_flag = 1'b1;
        end
        if (k_sat[KW-1]) begin
            k_mag       = KW'(-k_sat);
            regime_bits = {1'b1, {(SW-1){1'b0}}} >> k_mag;
            reg_len     = k_mag + KW'(1);
        end else begin
            k_mag       = k_sat;
            regime_bits = ~({SW{1'b1}} >> (k_mag + KW'(1)));
            reg_len     = k_mag + KW'(2);
        end
        body     = {Exp_DI, Mant_DI[N-2:0], {PAD{1'b0}}};
        wide     = {body, {N{1'b0}}} >> reg_len;
        str_next = regime_bits | wide[SW+N-1:N];
        spill    = |wide[N-1:0];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        str_d      = str_q;
        sign_d     = sign_q;
        nar_d      = nar_q;
        zero_d     = zero_q;
        sticky_d   = sticky_q;
        sat_d      = sat_q;
        if (Kill_SI) begin
            s1_valid_d = 1'b0;
        end else if (in_fire) begin
            s1_valid_d = 1'b1;
            str_d      = str_next;
            sign_d     = Sign_DI;
            nar_d      = NaR_DI;
            zero_d     = Zero_DI;
            sticky_d   = Sticky_DI | spill;
            sat_d      = sat_flag;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    logic [N-2:0] mag;
    logic         guard;
    logic         st_all;
    logic         round_up;
    logic [N-1:0] sum;
    logic [N-2:0] mag_f;
    logic [N-1:0] packed_res;
    logic [N-1:0] enc_res;
    logic         enc_inexact;
    logic         enc_invalid;

    // Rounding never leaves the representable range: overflow pins to maxpos, zero lifts to minpos.
    always_comb begin
        mag      = str_q[SW-1:N+1];
        guard    = str_q[N];
        st_all   = (|str_q[N-1:0]) | sticky_q;
        round_up = guard && (mag[0] || st_all);
        sum      = {1'b0, mag} + N'(round_up);
        if (sum[N-1]) begin
            mag_f = '1;
        end else if (sum[N-2:0] == '0) begin
            mag_f = (N-1)'(1);
        end else begin
            mag_f = sum[N-2:0];
        end
        packed_res = sign_q ? N'(-{1'b0, mag_f}) : {1'b0, mag_f};
        if (nar_q) begin
            enc_res     = {1'b1, {(N-1){1'b0}}};
            enc_inexact = 1'b0;
            enc_invalid = 1'b1;
        end else if (zero_q) begin
            enc_res     = '0;
            enc_inexact = 1'b0;
            enc_invalid = 1'b0;
        end else begin
            enc_res     = packed_res;
            enc_inexact = guard | st_all | sat_q;
            enc_invalid = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        inexact_d  = inexact_q;
        invalid_d  = invalid_q;
        if (Kill_SI) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d  = enc_res;
                inexact_d = enc_inexact;
                invalid_d = enc_invalid;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            s1_valid_q <= 1'b0;
            str_q      <= '0;
            sign_q     <= 1'b0;
            nar_q      <= 1'b0;
            zero_q     <= 1'b0;
            sticky_q   <= 1'b0;
            sat_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            inexact_q  <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            str_q      <= str_d;
            sign_q     <= sign_d;
            nar_q      <= nar_d;
            zero_q     <= zero_d;
            sticky_q   <= sticky_d;
            sat_q      <= sat_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            inexact_q  <= inexact_d;
            invalid_q  <= invalid_d;
        end
    end

    assign Out_valid_SO = s2_valid_q;
    assign Result_DO    = result_q;
    assign Inexact_SO   = inexact_q;
    assign Invalid_SO   = invalid_q;

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Self-checking bench for posit_encode_pipe: a bit-serial reference model feeds a
// scoreboard queue on every accepted input; results are popped as they leave the DUT.
module tb_posit_encode_pipe;

    logic        Clk_CI;
    logic        Rst_RI;
    logic        Kill_SI;
    logic        In_valid_SI;
    logic        In_ready_SO;
    logic        Sign_DI;
    logic [6:0]  Regime_DI;
    logic [1:0]  Exp_DI;
    logic [31:0] Mant_DI;
    logic        Sticky_DI;
    logic        NaR_DI;
    logic        Zero_DI;
    logic        Out_valid_SO;
    logic        Out_ready_SI;
    logic [31:0] Result_DO;
    logic        Inexact_SO;
    logic        Invalid_SO;

    posit_encode_pipe #(.N(32), .ES(2)) dut (
        .Clk_CI      (Clk_CI),
        .Rst_RI      (Rst_RI),
        .Kill_SI     (Kill_SI),
        .In_valid_SI (In_valid_SI),
        .In_ready_SO (In_ready_SO),
        .Sign_DI     (Sign_DI),
        .Regime_DI   (Regime_DI),
        .Exp_DI      (Exp_DI),
        .Mant_DI     (Mant_DI),
        .Sticky_DI   (Sticky_DI),
        .NaR_DI      (NaR_DI),
        .Zero_DI     (Zero_DI),
        .Out_valid_SO(Out_valid_SO),
        .Out_ready_SI(Out_ready_SI),
        .Result_DO   (Result_DO),
        .Inexact_SO  (Inexact_SO),
        .Invalid_SO  (Invalid_SO)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    typedef struct packed {
        logic [31:0] res;
        logic        inex;
        logic        inv;
    } exp_t;

    typedef struct packed {
        logic        s;
        logic [6:0]  k;
        logic [1:0]  e;
        logic [31:0] m;
        logic        st;
        logic        nar;
        logic        zero;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: append regime, exponent and fraction bits one at a time, then round.
    function automatic exp_t model(input vec_t v);
        exp_t   r;
        bit     bits[$];
        int     kk;
        bit     sat;
        bit     g;
        bit     sti;
        longint mag;
        r = '0;
        if (v.nar) begin
            r.res = 32'h8000_0000;
            r.inv = 1'b1;
            return r;
        end
        if (v.zero) return r;
        kk  = int'($signed(v.k));
        sat = 1'b0;
        if (kk > 30)  begin kk = 30;  sat = 1'b1; end
        if (kk < -30) begin kk = -30; sat = 1'b1; end
        if (kk >= 0) begin
            repeat (kk + 1) bits.push_back(1'b1);
            bits.push_back(1'b0);
        end else begin
            repeat (-kk) bits.push_back(1'b0);
            bits.push_back(1'b1);
        end
        bits.push_back(v.e[1]);
        bits.push_back(v.e[0]);
        for (int i = 30; i >= 0; i--) bits.push_back(v.m[i]);
        mag = 0;
        for (int i = 0; i < 31; i++) mag = (mag << 1) | longint'(bits[i]);
        g   = bits[31];
        sti = v.st;
        for (int i = 32; i < bits.size(); i++) sti |= bits[i];
        if (g && (mag[0] || sti)) mag++;
        if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
        if (mag == 0) mag = 1;
        r.res  = v.s ? 32'(-mag) : 32'(mag);
        r.inex = g | sti | sat;
        return r;
    endfunction

    // Presents one input until accepted (bounded); pushes the model result on acceptance.
    task automatic send(input vec_t v, output bit ok);
        Sign_DI     = v.s;
        Regime_DI   = v.k;
        Exp_DI      = v.e;
        Mant_DI     = v.m;
        Sticky_DI   = v.st;
        NaR_DI      = v.nar;
        Zero_DI     = v.zero;
        In_valid_SI = 1'b1;
        ok          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (In_ready_SO) begin
                ok = 1'b1;
                sb.push_back(model(v));
            end
            @(posedge Clk_CI);
            #1;
            if (ok) break;
        end
        In_valid_SI = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: In_ready_SO stuck at %b, required 1", In_ready_SO);
        end
    endtask

    task automatic test_reset();
        Rst_RI = 1'b1;
        repeat (2) @(posedge Clk_CI);
        #1;
        checks++;
        if ({Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%b res=%h inex=%b inv=%b, required all 0",
                     Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO);
        end
        Rst_RI = 1'b0;
    endtask

    task automatic test_encode();
        vec_t tbl[$];
        vec_t v;
        exp_t e;
        bit   ok;
        int   ki;
        tbl.push_back('{1'b0, 7'd0,      2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 7'd0,      2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd1,      2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd40,     2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'(-40),   2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd0,      2'd0, 32'h8000_0008, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd0,      2'd0, 32'h8000_0018, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd5,      2'd1, 32'h8123_4567, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 7'd5,      2'd1, 32'h8123_4567, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 7'd30,     2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd30,     2'd0, 32'h8000_0001, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'(-30),   2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 7'd0,      2'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 7'd29,     2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            ki = int'($urandom_range(0, 80)) - 40;
            tbl.push_back('{1'($urandom_range(0, 1)), 7'(ki), 2'($urandom),
                            {1'b1, 31'($urandom)}, 1'($urandom_range(0, 1)), 1'b0, 1'b0});
        end
        Out_ready_SI = 1'b1;
        foreach (tbl[i]) begin
            v = tbl[i];
            send(v, ok);
            if (!ok) continue;
            checks++;
            if (Out_valid_SO !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latency_early[%0d]: Out_valid_SO=%b one cycle after accept, required 0",
                         i, Out_valid_SO);
            end
            @(posedge Clk_CI);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL encode[%0d] k=%0d m=%h: got valid=%b res=%h inex=%b inv=%b, required valid=1 res=%h inex=%b inv=%b",
                         i, $signed(v.k), v.m, Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO,
                         e.res, e.inex, e.inv);
            end
        end
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic test_back_to_back();
        vec_t        items[4];
        logic [31:0] held;
        exp_t        e;
        int          got;
        for (int i = 0; i < 4; i++)
            items[i] = '{1'b0, 7'(i), 2'(i), 32'h8000_0000 | (32'h0123_4000 * (i + 1)), 1'b0, 1'b0, 1'b0};
        Out_ready_SI = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 4; i++) send(items[i], ok);
            end
            begin
                repeat (2) @(posedge Clk_CI);
                #1;
                held = Result_DO;
                checks++;
                if (sb.size() == 0 || Out_valid_SO !== 1'b1 || Result_DO !== sb[0].res) begin
                    errors++;
                    $display("[TB] FAIL b2b_first: got valid=%b res=%h, required valid=1 res=%h",
                             Out_valid_SO, Result_DO, (sb.size() > 0) ? sb[0].res : 32'h0);
                end
                for (int c = 0; c < 3; c++) begin
                    checks++;
                    if (In_ready_SO !== 1'b0 || Out_valid_SO !== 1'b1 || Result_DO !== held) begin
                        errors++;
                        $display("[TB] FAIL b2b_stall[%0d]: got ready=%b valid=%b res=%h, required ready=0 valid=1 res=%h",
                                 c, In_ready_SO, Out_valid_SO, Result_DO, held);
                    end
                    @(posedge Clk_CI);
                    #1;
                end
                Out_ready_SI = 1'b1;
                got = 0;
                for (int c = 0; c < 40 && got < 4; c++) begin
                    if (Out_valid_SO && Out_ready_SI && sb.size() > 0) begin
                        e = sb.pop_front();
                        got++;
                        checks++;
                        if ({Result_DO, Inexact_SO, Invalid_SO} !== e) begin
                            errors++;
                            $display("[TB] FAIL b2b_order[%0d]: got res=%h inex=%b inv=%b, required res=%h inex=%b inv=%b",
                                     got - 1, Result_DO, Inexact_SO, Invalid_SO, e.res, e.inex, e.inv);
                        end
                    end
                    @(posedge Clk_CI);
                    #1;
                end
                checks++;
                if (got != 4) begin
                    errors++;
                    $display("[TB] FAIL b2b_count: got %0d results, required 4", got);
                end
            end
        join
    endtask

    task automatic test_kill();
        vec_t a;
        exp_t e;
        bit   ok;
        a = '{1'b0, 7'd2, 2'd1, 32'hC000_0000, 1'b0, 1'b0, 1'b0};
        Out_ready_SI = 1'b0;
        send(a, ok);
        send(a, ok);
        Kill_SI     = 1'b1;
        In_valid_SI = 1'b1;
        Regime_DI   = 7'd3;
        #1;
        checks++;
        if (In_ready_SO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kill_ready: got In_ready_SO=%b, required 0", In_ready_SO);
        end
        @(posedge Clk_CI);
        #1;
        Kill_SI     = 1'b0;
        In_valid_SI = 1'b0;
        sb.delete();
        checks++;
        if (Out_valid_SO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kill_flush: got Out_valid_SO=%b, required 0", Out_valid_SO);
        end
        Out_ready_SI = 1'b1;
        repeat (2) @(posedge Clk_CI);
        #1;
        checks++;
        if (Out_valid_SO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kill_no_accept: got Out_valid_SO=%b, required 0", Out_valid_SO);
        end
        a = '{1'b1, 7'(-3), 2'd2, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0};
        send(a, ok);
        if (ok) begin
            @(posedge Clk_CI);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL kill_recover: got valid=%b res=%h inex=%b, required valid=1 res=%h inex=%b",
                         Out_valid_SO, Result_DO, Inexact_SO, e.res, e.inex);
            end
        end
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic test_reset_midstream();
        vec_t a;
        exp_t e;
        bit   ok;
        Out_ready_SI = 1'b0;
        a = '{1'b0, 7'd40, 2'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        send(a, ok);
        a = '{1'b0, 7'd1, 2'd3, 32'hF000_0000, 1'b0, 1'b0, 1'b0};
        send(a, ok);
        Rst_RI = 1'b1;
        @(posedge Clk_CI);
        #1;
        Rst_RI = 1'b0;
        sb.delete();
        checks++;
        if ({Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_midstream: got valid=%b res=%h inex=%b inv=%b, required all 0",
                     Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO);
        end
        Out_ready_SI = 1'b1;
        a = '{1'b0, 7'(-2), 2'd1, 32'h9000_0000, 1'b0, 1'b0, 1'b0};
        send(a, ok);
        if (ok) begin
            checks++;
            if (Out_valid_SO !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_early: got Out_valid_SO=%b, required 0", Out_valid_SO);
            end
            @(posedge Clk_CI);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Out_valid_SO, Result_DO, Inexact_SO, Invalid_SO} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL post_reset_result: got valid=%b res=%h inex=%b, required valid=1 res=%h inex=%b",
                         Out_valid_SO, Result_DO, Inexact_SO, e.res, e.inex);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Rst_RI       = 1'b1;
        Kill_SI      = 1'b0;
        In_valid_SI  = 1'b0;
        Out_ready_SI = 1'b1;
        Sign_DI      = 1'b0;
        Regime_DI    = '0;
        Exp_DI       = '0;
        Mant_DI      = '0;
        Sticky_DI    = 1'b0;
        NaR_DI       = 1'b0;
        Zero_DI      = 1'b0;
        test_reset();
        test_encode();
        test_back_to_back();
        test_kill();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
- Two-stage pipelined posit encoder: packs decoded fields (sign, regime k, exponent, hidden-bit mantissa, sticky) into an N-bit posit.
- Applies round-to-nearest-even and posit saturation (never rounds to zero or NaR).
- Performs the inverse of the field extraction that feeds the div/sqrt datapath; instantiated at the output of posit arithmetic units.
- Elastic valid/ready handshake on both sides; flush via kill.

Parameters:
- N, 32, posit width in bits
- ES, 2, exponent field width
- RS, $clog2(N), regime magnitude width; regime input is signed RS+2 bits

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset; synchronous, active-high
- Kill_SI  in  1  flush both stages
- In_valid_SI  in  1  input fields valid
- In_ready_SO  out  1  encoder accepts input this cycle
- Sign_DI  in  1  sign of result
- Regime_DI  in  RS+2  signed regime k
- Exp_DI  in  ES  exponent field
- Mant_DI  in  N  mantissa; bit N-1 is the hidden 1, bits N-2:0 are fraction
- Sticky_DI  in  1  OR of discarded lower bits from upstream
- NaR_DI  in  1  force NaR
- Zero_DI  in  1  force zero
- Out_valid_SO  out  1  result valid
- Out_ready_SI  in  1  downstream accepts result
- Result_DO  out  N  encoded posit
- Inexact_SO  out  1  rounding discarded nonzero bits, or saturation occurred
- Invalid_SO  out  1  result is NaR

Behaviour:
- Reset (Rst_RI high at a clock edge): both stage valids 0, Out_valid_SO=0, Result_DO=0, Inexact_SO=0, Invalid_SO=0. Reset overrides the handshake and kill. Any in-flight data is dropped.
- Handshake:
  - Transfer in when In_valid_SI & In_ready_SO.
  - Transfer out when Out_valid_SO & Out_ready_SI.
  - s2 advances when !s2_valid | Out_ready_SI.
  - In_ready_SO = !s1_valid | s1_advance, where s1 advances when s2 advances.
  - Full throughput: 1 result/cycle. Latency: 2 cycles from accept to Out_valid_SO.
  - Outputs are registered and held stable while Out_valid_SO & !Out_ready_SI.
- Kill_SI: clears s1_valid and s2_valid at the next edge. In_ready_SO=0 during the kill cycle; input presented in that cycle is not accepted.
- Stage 1 (build):
  - Clamp k to [-(N-2), N-2]; set sat_flag if clamped.
  - Regime string: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
  - Form the bit string regime||Exp_DI||Mant_DI[N-2:0], left-aligned into a 2N-bit register.
  - Register the string, Sign, NaR, Zero, Sticky_DI, sat_flag.
- Stage 2 (round/pack):
  - mag = top N-1 bits; guard = next bit; sticky = OR of remaining bits | registered Sticky.
  - Round up when guard & (mag[0] | sticky).
  - Saturate: a rounded mag of all-ones+1 stays 0x…7FF (maxpos); a rounded mag of 0 becomes 1 (minpos).
  - Result = Sign ? two's complement of {0,mag} : {0,mag}.
  - Inexact = guard | sticky | sat_flag.
- Specials:
  - NaR_DI has priority: Result = 1 followed by N-1 zeros; Invalid=1; Inexact=0.
  - Zero_DI (without NaR): Result=0; flags 0.
  - Special inputs ignore all other fields.
- Boundaries:
  - k=N-2 encodes maxpos exactly (Inexact only if exponent/fraction bits are nonzero).
  - k=-(N-2) gives minpos.
  - Out-of-range k saturates with Inexact=1.
  - Simultaneous input accept and output transfer with both stages full is legal and lossless.

Test Plan:
- N=32, ES=2. Inputs k=0, Exp=0, Mant=0x80000000 -> Result 0x40000000 two cycles after accept, Inexact=0. Same with Sign=1 -> 0xC0000000.
- k=1, Exp=0, Mant=0x80000000 -> 0x60000000. k=40 -> 0x7FFFFFFF, Inexact=1. k=-40 -> 0x00000001, Inexact=1.
- k=0, Exp=0: Mant=0x80000008 -> 0x40000000, Inexact=1 (tie, even). Mant=0x80000018 -> 0x40000002, Inexact=1 (tie, odd, round up).
- NaR_DI=1 with Zero_DI=1 -> 0x80000000, Invalid=1. Zero_DI only -> 0x00000000, flags 0.
- Stream 4 inputs back-to-back with Out_ready_SI=0 for 5 cycles: In_ready_SO drops after 2 accepted, Result_DO is held stable, and all 4 results emerge in order once ready rises.
- Assert Kill_SI with both stages full -> Out_valid_SO=0 next cycle. Assert Rst_RI mid-stream -> all outputs 0 next cycle, and the first post-reset input yields its correct result at 2-cycle latency.
